trees_job_scheduler: RTL and testbench

//  Hardware job sequencer in front of trees_rtl_basic_dma64. Takes one job:
//   - optional tree load;
//   - N samples, split into bursts of at most MAX_BURST.
//  It drives the accelerator conf interface once per burst.
//  It rebases the accelerator's DMA read/write indices, so each burst reads its
//  own feature slice and writes its own prediction slice.

---
 rtl/trees_job_scheduler_pkg.sv | 24 ++
 rtl/trees_job_scheduler_if.sv | 35 +++
 rtl/trees_job_scheduler_dma_index_rebase.sv | 41 ++++
 rtl/trees_job_scheduler.sv | 166 ++++++++++++++++
 tb/tb_trees_job_scheduler.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/trees_job_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// trees_job_scheduler_pkg
// Shared types and helpers for the tree-accelerator job scheduler.
//   state_e      : scheduler FSM states
//   clamp_burst(): maps the runtime burst cap onto 1..max_b (0 means "use max")
// ----------------------------------------------------------------------------
package trees_job_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TREE_CONF,
        S_TREE_WAIT,
        S_CHUNK_CONF,
        S_CHUNK_WAIT,
        S_DONE
    } state_e;

    // Done on 64 bits so callers of any index width up to 64 can share it.
    function automatic logic [63:0] clamp_burst(input logic [63:0] cap,
                                                input logic [63:0] max_b);
        return ((cap == 64'd0) || (cap > max_b)) ? max_b : cap;
    endfunction

endpackage

// File: rtl/trees_job_scheduler_if.sv
// ----------------------------------------------------------------------------
// trees_job_scheduler_if
// Job request / status bundle between software-facing logic (master) and the
// scheduler (slave).
//   job_start .. job_pred_base : job request fields, sampled on job_start
//   job_busy, job_done, job_aborted, job_samples_done : job status
// ----------------------------------------------------------------------------
interface trees_job_scheduler_if #(
    parameter int IDX_W = 32
);
    logic             job_start;
    logic             job_abort;
    logic             job_load_trees;
    logic [IDX_W-1:0] job_n_samples;
    logic [IDX_W-1:0] job_max_burst;
    logic [IDX_W-1:0] job_tree_base;
    logic [IDX_W-1:0] job_feat_base;
    logic [IDX_W-1:0] job_pred_base;
    logic             job_busy;
    logic             job_done;
    logic             job_aborted;
    logic [IDX_W-1:0] job_samples_done;

    modport master (
        output job_start, job_abort, job_load_trees, job_n_samples, job_max_burst,
               job_tree_base, job_feat_base, job_pred_base,
        input  job_busy, job_done, job_aborted, job_samples_done
    );

    modport slave (
        input  job_start, job_abort, job_load_trees, job_n_samples, job_max_burst,
               job_tree_base, job_feat_base, job_pred_base,
        output job_busy, job_done, job_aborted, job_samples_done
    );
endinterface

// File: rtl/trees_job_scheduler_dma_index_rebase.sv
// ----------------------------------------------------------------------------
// trees_dma_index_rebase
// Adds per-run offsets to the accelerator's DMA beat indices so each run
// addresses its own slice of memory.
//   clk, rst          : clock, async active-low reset (offsets -> 0)
//   i_ld_rd, i_rd_off : load read offset
//   i_ld_wr, i_wr_off : load write offset
//   i_acc_rd_index    : accelerator read index   -> o_dma_rd_index (+ rd offset)
//   i_acc_wr_index    : accelerator write index  -> o_dma_wr_index (+ wr offset)
// ----------------------------------------------------------------------------
module trees_dma_index_rebase #(
    parameter int IDX_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_ld_rd,
    input  logic [IDX_W-1:0] i_rd_off,
    input  logic             i_ld_wr,
    input  logic [IDX_W-1:0] i_wr_off,
    input  logic [IDX_W-1:0] i_acc_rd_index,
    input  logic [IDX_W-1:0] i_acc_wr_index,
    output logic [IDX_W-1:0] o_dma_rd_index,
    output logic [IDX_W-1:0] o_dma_wr_index
);
    logic [IDX_W-1:0] r_rd_off;
    logic [IDX_W-1:0] r_wr_off;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_off <= '0;
            r_wr_off <= '0;
        end else begin
            if (i_ld_rd) r_rd_off <= i_rd_off;
            if (i_ld_wr) r_wr_off <= i_wr_off;
        end
    end

    // Combinational so the accelerator's own index timing is preserved.
    assign o_dma_rd_index = i_acc_rd_index + r_rd_off;
    assign o_dma_wr_index = i_acc_wr_index + r_wr_off;
endmodule

// File: rtl/trees_job_scheduler.sv
// ----------------------------------------------------------------------------
// trees_job_scheduler
// Sequences one job on the tree accelerator: optional tree-load run, then the
// samples split into bursts of at most the clamped cap, rebasing DMA indices
// per burst.
//   clk, rst                   : clock, async active-low reset
//   job (slave modport)        : job request fields and status
//   o_acc_conf_info_load_trees : accelerator conf, tree-load run
//   o_acc_conf_info_burst_len  : accelerator conf, samples in this run
//   o_acc_conf_done            : 1-cycle conf strobe
//   i_acc_done                 : accelerator run finished
//   i_acc_rd/wr_index          : accelerator DMA indices
//   o_dma_rd/wr_index          : rebased DMA indices
// ----------------------------------------------------------------------------
module trees_job_scheduler
    import trees_job_scheduler_pkg::*;
#(
    parameter int N_FEATURE     = 32,
    parameter int MAX_BURST     = 5000,
    parameter int PRED_PER_BEAT = 1,
    parameter int IDX_W         = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    trees_job_scheduler_if.slave  job,
    output logic                  o_acc_conf_info_load_trees,
    output logic [IDX_W-1:0]      o_acc_conf_info_burst_len,
    output logic                  o_acc_conf_done,
    input  logic                  i_acc_done,
    input  logic [IDX_W-1:0]      i_acc_rd_index,
    input  logic [IDX_W-1:0]      i_acc_wr_index,
    output logic [IDX_W-1:0]      o_dma_rd_index,
    output logic [IDX_W-1:0]      o_dma_wr_index
);
    // Two fp32 features per 64-bit beat; constant multiply reduces to a shift.
    localparam logic [IDX_W-1:0] FEAT_BEATS = IDX_W'(N_FEATURE / 2);

    if (PRED_PER_BEAT != 1) begin : g_bad_ppb
        $error("trees_job_scheduler: PRED_PER_BEAT must be 1");
    end

    state_e           r_state, w_next;
    logic             w_accept, w_acc_ack, w_abort;
    logic [IDX_W-1:0] w_chunk;

    logic             r_busy, r_done, r_aborted, r_abort_pend;
    logic [IDX_W-1:0] r_cap, r_tree_base, r_feat_base, r_pred_base;
    logic [IDX_W-1:0] r_remaining, r_chunk, r_samples_done;
    logic             r_conf_ld, r_conf_done;
    logic [IDX_W-1:0] r_conf_len;

    // An abort raised in the same cycle as acc_done still counts.
    assign w_abort = r_abort_pend | job.job_abort;
    assign w_chunk = (r_remaining < r_cap) ? r_remaining : r_cap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_acc_ack = 1'b0;
        case (r_state)
            S_IDLE: if (job.job_start) begin
                w_accept = 1'b1;
                if (job.job_load_trees)          w_next = S_TREE_CONF;
                else if (job.job_n_samples != 0) w_next = S_CHUNK_CONF;
                else                             w_next = S_DONE;
            end
            S_TREE_CONF:  w_next = S_TREE_WAIT;
            S_TREE_WAIT:  if (i_acc_done)
                w_next = (w_abort || r_remaining == 0) ? S_DONE : S_CHUNK_CONF;
            S_CHUNK_CONF: w_next = S_CHUNK_WAIT;
            S_CHUNK_WAIT: if (i_acc_done) begin
                w_acc_ack = 1'b1;
                // remaining reaches zero once this chunk is retired
                w_next = (w_abort || r_remaining == r_chunk) ? S_DONE : S_CHUNK_CONF;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Conf outputs are registered while the FSM sits in a *_CONF state, so the
    // strobe lands together with the freshly loaded offsets.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_aborted      <= 1'b0;
            r_abort_pend   <= 1'b0;
            r_cap          <= '0;
            r_tree_base    <= '0;
            r_feat_base    <= '0;
            r_pred_base    <= '0;
            r_remaining    <= '0;
            r_chunk        <= '0;
            r_samples_done <= '0;
            r_conf_ld      <= 1'b0;
            r_conf_len     <= '0;
            r_conf_done    <= 1'b0;
        end else begin
            r_conf_done <= 1'b0;
            r_done      <= 1'b0;
            if (w_accept) begin
                r_busy         <= 1'b1;
                r_aborted      <= 1'b0;
                r_abort_pend   <= 1'b0;
                r_cap          <= IDX_W'(clamp_burst(64'(job.job_max_burst), 64'(MAX_BURST)));
                r_tree_base    <= job.job_tree_base;
                r_feat_base    <= job.job_feat_base;
                r_pred_base    <= job.job_pred_base;
                r_remaining    <= job.job_n_samples;
                r_samples_done <= '0;
            end else if (r_busy && job.job_abort) begin
                r_abort_pend <= 1'b1;
            end
            if (r_state == S_TREE_CONF) begin
                r_conf_ld   <= 1'b1;
                r_conf_len  <= '0;
                r_conf_done <= 1'b1;
            end
            if (r_state == S_CHUNK_CONF) begin
                r_conf_ld   <= 1'b0;
                r_conf_len  <= w_chunk;
                r_chunk     <= w_chunk;
                r_conf_done <= 1'b1;
            end
            if (w_acc_ack) begin
                r_samples_done <= r_samples_done + r_chunk;
                r_remaining    <= r_remaining - r_chunk;
            end
            if (i_acc_done && w_next == S_DONE &&
                (r_state == S_TREE_WAIT || r_state == S_CHUNK_WAIT))
                r_aborted <= w_abort;
            if (r_state == S_DONE) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    trees_dma_index_rebase #(.IDX_W(IDX_W)) u_rebase (
        .clk            (clk),
        .rst            (rst),
        .i_ld_rd        (r_state == S_TREE_CONF || r_state == S_CHUNK_CONF),
        .i_rd_off       ((r_state == S_TREE_CONF) ? r_tree_base
                                                  : r_feat_base + r_samples_done * FEAT_BEATS),
        .i_ld_wr        (r_state == S_CHUNK_CONF),
        .i_wr_off       (r_pred_base + r_samples_done),
        .i_acc_rd_index (i_acc_rd_index),
        .i_acc_wr_index (i_acc_wr_index),
        .o_dma_rd_index (o_dma_rd_index),
        .o_dma_wr_index (o_dma_wr_index)
    );

    assign job.job_busy                = r_busy;
    assign job.job_done                = r_done;
    assign job.job_aborted             = r_aborted;
    assign job.job_samples_done        = r_samples_done;
    assign o_acc_conf_info_load_trees  = r_conf_ld;
    assign o_acc_conf_info_burst_len   = r_conf_len;
    assign o_acc_conf_done             = r_conf_done;
endmodule

// File: tb/tb_trees_job_scheduler.sv
module tb_trees_job_scheduler;
    localparam logic [31:0] MAX_B = 32'd5000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        acc_done = 1'b0;
    logic [31:0] acc_rd = '0, acc_wr = '0;
    logic        conf_ld, conf_done;
    logic [31:0] conf_len, dma_rd, dma_wr;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] m_wr = '0;   // prediction offset the DUT should be holding
    logic [31:0] m_sd = '0;   // samples_done after the last job

    trees_job_scheduler_if #(.IDX_W(32)) jif ();

    trees_job_scheduler dut (
        .clk                        (clk),
        .rst                        (rst),
        .job                        (jif),
        .o_acc_conf_info_load_trees (conf_ld),
        .o_acc_conf_info_burst_len  (conf_len),
        .o_acc_conf_done            (conf_done),
        .i_acc_done                 (acc_done),
        .i_acc_rd_index             (acc_rd),
        .i_acc_wr_index             (acc_wr),
        .o_dma_rd_index             (dma_rd),
        .o_dma_wr_index             (dma_wr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Builds the expected run list from the job rules, then plays accelerator.
    task automatic run_job(input bit ld, input logic [31:0] n, input logic [31:0] cap,
                           input logic [31:0] tbase, input logic [31:0] fbase,
                           input logic [31:0] pbase, input int abort_at, input bit dbl);
        bit          eld[$];
        logic [31:0] elen[$], erd[$], ewr[$], esd[$];
        logic [31:0] capc, rem, sd, c, exp_sd;
        int          esz, k, idle, lat, dly;
        bit          first, fin, exp_ab;

        capc = (cap == 0 || cap > MAX_B) ? MAX_B : cap;
        if (ld) begin
            eld.push_back(1'b1); elen.push_back(0); erd.push_back(tbase);
            ewr.push_back(m_wr); esd.push_back(0);
        end
        rem = n; sd = 0;
        while (rem != 0) begin
            c = (rem < capc) ? rem : capc;
            eld.push_back(1'b0); elen.push_back(c); erd.push_back(32'(fbase + sd * 16));
            ewr.push_back(32'(pbase + sd)); esd.push_back(sd);
            sd += c; rem -= c;
        end
        esz = eld.size(); exp_ab = 1'b0;
        if (abort_at >= 0 && abort_at < esz) begin esz = abort_at + 1; exp_ab = 1'b1; end
        exp_sd = (esz > 0) ? 32'(esd[esz-1] + elen[esz-1]) : 32'd0;
        for (int i = 0; i < esz; i++) if (ewr.size() > i && !eld[i]) m_wr = ewr[i];
        // tree conf rows carry the wr offset in force when they issue
        for (int i = 0; i < esz; i++) if (eld[i]) ewr[i] = (i == 0) ? ewr[i] : ewr[i-1];

        jif.job_load_trees = ld;   jif.job_n_samples = n;     jif.job_max_burst = cap;
        jif.job_tree_base  = tbase; jif.job_feat_base = fbase; jif.job_pred_base = pbase;
        jif.job_start = 1'b1;
        @(negedge clk);
        jif.job_start = 1'b0;
        jif.job_load_trees = 1'($urandom); jif.job_n_samples = $urandom; jif.job_max_burst = $urandom;
        jif.job_tree_base  = $urandom; jif.job_feat_base = $urandom; jif.job_pred_base = $urandom;
        chk("busy_after_start", jif.job_busy, 1);
        chk("aborted_clr", jif.job_aborted, 0);

        lat = 1; idle = 0; k = 0; first = 0; fin = 0;
        while (!fin) begin
            if (conf_done) begin
                if (!first) begin chk("start_lat", lat, 2); first = 1; end
                if (k < esz) begin
                    chk("conf_ld", conf_ld, eld[k]);
                    chk("conf_len", conf_len, elen[k]);
                    chk("sd_at_conf", jif.job_samples_done, esd[k]);
                    acc_rd = $urandom; acc_wr = $urandom;
                    #1;
                    chk("dma_rd", dma_rd, 32'(acc_rd + erd[k]));
                    chk("dma_wr", dma_wr, 32'(acc_wr + ewr[k]));
                end else chk("extra_conf", k, esz);
                dly = $urandom_range(1, 4);
                for (int i = 0; i < dly; i++) begin
                    jif.job_abort = (i == 0 && k == abort_at);
                    jif.job_start = (i == 0 && dbl && k == 0);
                    @(negedge clk);
                end
                jif.job_abort = 1'b0; jif.job_start = 1'b0;
                acc_done = 1'b1;
                @(negedge clk);
                acc_done = 1'b0;
                k++; idle = 0;
            end else if (jif.job_done) begin
                if (!first) begin chk("start_lat", lat, 2); first = 1; end
                chk("n_confs", k, esz);
                chk("aborted", jif.job_aborted, exp_ab);
                chk("samples_done", jif.job_samples_done, exp_sd);
                chk("busy_at_done", jif.job_busy, 0);
                if (esz > 0) chk("hold_len", conf_len, elen[esz-1]);
                fin = 1;
            end else begin
                @(negedge clk);
                lat++; idle++;
                if (idle > 50) begin chk("timeout", idle, 0); fin = 1; end
            end
        end
        @(negedge clk);
        chk("done_pulse", jif.job_done, 0);
        m_sd = exp_sd;
    endtask

    initial begin
        int t;
        jif.job_start = 0; jif.job_abort = 0; jif.job_load_trees = 0;
        jif.job_n_samples = 0; jif.job_max_burst = 0; jif.job_tree_base = 0;
        jif.job_feat_base = 0; jif.job_pred_base = 0;
        acc_rd = 32'h1234_5678; acc_wr = 32'h0bad_cafe;
        repeat (2) @(negedge clk);
        chk("rst_busy", jif.job_busy, 0);
        chk("rst_done", jif.job_done, 0);
        chk("rst_aborted", jif.job_aborted, 0);
        chk("rst_sd", jif.job_samples_done, 0);
        chk("rst_conf_done", conf_done, 0);
        chk("rst_conf_len", conf_len, 0);
        chk("rst_conf_ld", conf_ld, 0);
        chk("rst_dma_rd", dma_rd, 32'h1234_5678);
        chk("rst_dma_wr", dma_wr, 32'h0bad_cafe);
        rst = 1'b1;
        @(negedge clk);

        run_job(1, 10000, 5000, 0, 0, 0, -1, 0);
        run_job(0, 7, 3, 0, 0, 100, -1, 0);
        run_job(0, 0, 3, 0, 0, 0, -1, 0);
        run_job(0, 9000, 0, 0, 32'h40, 32'h80, 0, 0);

        // stray acc_done and abort while idle must not disturb anything
        acc_done = 1'b1; jif.job_abort = 1'b1;
        repeat (2) @(negedge clk);
        acc_done = 1'b0; jif.job_abort = 1'b0;
        chk("idle_sd", jif.job_samples_done, m_sd);
        chk("idle_busy", jif.job_busy, 0);
        chk("idle_conf", conf_done, 0);
        run_job(0, 5, 2, 0, 32'h100, 32'h200, -1, 1);

        run_job(0, 5001, 7000, 0, 32'hFFFF_FFF0, 32'hFFFF_FFFE, -1, 0);
        run_job(1, 4, 2, 32'h77, 0, 0, 0, 0);

        // reset in the middle of the second burst
        jif.job_load_trees = 0; jif.job_n_samples = 7; jif.job_max_burst = 3;
        jif.job_feat_base = 0; jif.job_pred_base = 55; jif.job_start = 1;
        @(negedge clk); jif.job_start = 0;
        t = 0; while (!conf_done && t < 20) begin @(negedge clk); t++; end
        chk("pre_rst_conf1", conf_done, 1);
        @(negedge clk); acc_done = 1; @(negedge clk); acc_done = 0;
        t = 0; while (!conf_done && t < 20) begin @(negedge clk); t++; end
        chk("pre_rst_conf2", conf_done, 1);
        chk("pre_rst_sd", jif.job_samples_done, 3);
        @(negedge clk);
        acc_rd = 0; acc_wr = 0; rst = 1'b0;
        #1;
        chk("mid_rst_busy", jif.job_busy, 0);
        chk("mid_rst_done", jif.job_done, 0);
        chk("mid_rst_sd", jif.job_samples_done, 0);
        chk("mid_rst_len", conf_len, 0);
        chk("mid_rst_dma_rd", dma_rd, 0);
        chk("mid_rst_dma_wr", dma_wr, 0);
        @(negedge clk);
        rst = 1'b1; m_wr = 0;
        @(negedge clk);
        chk("post_rst_no_done", jif.job_done, 0);
        run_job(0, 7, 3, 0, 0, 55, -1, 0);

        for (int j = 0; j < 8; j++) begin
            int ab;
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_job(1'($urandom_range(0, 1)), $urandom_range(0, 12), $urandom_range(0, 6),
                    $urandom, $urandom, $urandom, ab, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
